// File: rtl/vga_stream_monitor.sv
// rtl/vga_stream_monitor.sv - VGA sink: timing check, lock tracking, pixel recovery, per-frame CRC-16 (optional probe: VGA_MON_PROBE_EN)
module vga_stream_monitor #(
    parameter int H_TOTAL      = 800,
    parameter int H_VIS_START  = 144,
    parameter int H_VISIBLE    = 640,
    parameter int V_TOTAL      = 525,
    parameter int V_VIS_START  = 35,
    parameter int V_VISIBLE    = 480,
    parameter bit SYNC_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixpulse,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_crc,
    output logic        locked,
    output logic        err_line,
    output logic        err_frame,
    output logic [7:0]  err_cnt
`ifdef VGA_MON_PROBE_EN
    ,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [11:0] probe_rgb,
    output logic        probe_hit
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] HC_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] HC_VS   = 11'(H_VIS_START);
    localparam logic [10:0] HC_VE   = 11'(H_VIS_START + H_VISIBLE - 1);
    localparam logic [9:0]  LC_TOT  = 10'(V_TOTAL);
    localparam logic [9:0]  LC_VS   = 10'(V_VIS_START);
    localparam logic [9:0]  LC_VE   = 10'(V_VIS_START + V_VISIBLE - 1);

    state_t      state, state_nxt;
    logic        hs_prev, vs_prev;
    logic [10:0] hc, hc_nxt;
    logic [9:0]  lc, lc_nxt;
    logic        skip_chk;
    logic        line_err_seen;
    logic [15:0] crc_acc;

    logic        hs_act, vs_act;
    logic        h_edge, v_edge;
    logic        line_bad, frame_ok, vis;
    logic        frame_done_nxt, err_frame_nxt;
    logic        enter_measure, cnt_inc;

    // CRC-16-CCITT over one 12-bit pixel, MSB first
    function automatic logic [15:0] crc_step12(input logic [15:0] c_in, input logic [11:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 11; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign hs_act = SYNC_ACT_LOW ? ~hsync : hsync;
    assign vs_act = SYNC_ACT_LOW ? ~vsync : vsync;
    assign h_edge = pixpulse & hs_act & ~hs_prev;
    assign v_edge = pixpulse & vs_act & ~vs_prev;
    assign locked = (state == LOCKED);

    // The first line measured after entering MEASURE may be partial, so its check is skipped
    assign line_bad = h_edge && (state != SEARCH) && !skip_chk && (hc != HC_LAST);
    assign frame_ok = !line_err_seen && !line_bad && (lc == LC_TOT);

    // Counter next values; a coincident vsync edge starts the frame on line 1
    always_comb begin
        hc_nxt = (hc == 11'h7FF) ? hc : hc + 11'd1;
        lc_nxt = lc;
        if (h_edge) hc_nxt = 11'd0;
        if (v_edge && h_edge)  lc_nxt = 10'd1;
        else if (v_edge)       lc_nxt = 10'd0;
        else if (h_edge)       lc_nxt = (lc == 10'h3FF) ? lc : lc + 10'd1;
    end

    assign vis = pixpulse && (state != SEARCH) &&
                 (hc_nxt >= HC_VS) && (hc_nxt <= HC_VE) &&
                 (lc_nxt >= LC_VS) && (lc_nxt <= LC_VE);

    // Lock FSM next state and frame-level pulses
    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        err_frame_nxt  = 1'b0;
        if (v_edge) begin
            case (state)
                SEARCH:  state_nxt = MEASURE;
                MEASURE: begin
                    if (frame_ok) begin
                        state_nxt      = LOCKED;
                        frame_done_nxt = 1'b1;
                    end
                end
                LOCKED: begin
                    if (frame_ok) begin
                        frame_done_nxt = 1'b1;
                    end else begin
                        state_nxt     = MEASURE;
                        err_frame_nxt = (lc != LC_TOT);
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
        if ((state == LOCKED) && line_bad) state_nxt = MEASURE;
    end

    assign enter_measure = (state_nxt == MEASURE) && (state != MEASURE);
    assign cnt_inc       = (state == LOCKED) && (line_bad || err_frame_nxt);

    // State register and sync/counter tracking on pixel strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            hs_prev       <= 1'b0;
            vs_prev       <= 1'b0;
            hc            <= 11'd0;
            lc            <= 10'd0;
            skip_chk      <= 1'b0;
            line_err_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pixpulse) begin
                hs_prev <= hs_act;
                vs_prev <= vs_act;
                hc      <= hc_nxt;
                lc      <= lc_nxt;
                if (v_edge)        line_err_seen <= 1'b0;
                else if (line_bad) line_err_seen <= 1'b1;
                if (enter_measure) skip_chk <= 1'b1;
                else if (h_edge)   skip_chk <= 1'b0;
            end
        end
    end

    // Pixel capture and running frame CRC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_rgb   <= 12'd0;
            crc_acc   <= 16'hFFFF;
        end else begin
            pix_valid <= 1'b0;
            if (vis) begin
                pix_valid <= 1'b1;
                pix_x     <= 10'(hc_nxt - HC_VS);
                pix_y     <= lc_nxt - LC_VS;
                pix_rgb   <= rgb;
            end
            if (v_edge)   crc_acc <= vis ? crc_step12(16'hFFFF, rgb) : 16'hFFFF;
            else if (vis) crc_acc <= crc_step12(crc_acc, rgb);
        end
    end

    // Frame result, error pulses and saturating error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_crc  <= 16'd0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            frame_done <= frame_done_nxt;
            err_line   <= line_bad;
            err_frame  <= err_frame_nxt;
            if (frame_done_nxt) frame_crc <= crc_acc;
            if (cnt_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef VGA_MON_PROBE_EN
    // Probe: flag and latch the pixel at the requested coordinate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_hit <= 1'b0;
            probe_rgb <= 12'd0;
        end else begin
            probe_hit <= 1'b0;
            if (vis && (10'(hc_nxt - HC_VS) == probe_x) && ((lc_nxt - LC_VS) == probe_y)) begin
                probe_hit <= 1'b1;
                probe_rgb <= rgb;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_stream_monitor.sv
// tb/tb_vga_stream_monitor.sv - directed bench for vga_stream_monitor on a reduced raster
module tb_vga_stream_monitor;

    localparam int HT = 20, HVS = 4, HV = 8, VT = 12, VVS = 3, VV = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixpulse = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [11:0] rgb = 12'd0;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic [15:0] frame_crc;
    logic        locked, err_line, err_frame;
    logic [7:0]  err_cnt;

    int n_pass = 0, n_total = 0;
    int nvalid, rgb_bad, n_done, n_eline, n_eframe;
    int first_x, first_y, last_x, last_y;
    logic [15:0] last_crc;
    logic lock_first;

    vga_stream_monitor #(
        .H_TOTAL(HT), .H_VIS_START(HVS), .H_VISIBLE(HV),
        .V_TOTAL(VT), .V_VIS_START(VVS), .V_VISIBLE(VV), .SYNC_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_crc(frame_crc), .locked(locked),
        .err_line(err_line), .err_frame(err_frame), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [15:0] crc_model(input int mode);
        logic [15:0] c;
        logic [11:0] v;
        c = 16'hFFFF;
        for (int y = 0; y < VV; y++) begin
            for (int x = 0; x < HV; x++) begin
                v = (mode != 0) ? {4'(x), 4'(y), 4'h5} : 12'hFFF;
                for (int b = 11; b >= 0; b--) begin
                    if ((c >> 15) != 16'(v[b])) c = (c << 1) ^ 16'h1021;
                    else                        c = c << 1;
                end
            end
        end
        return c;
    endfunction

    // Drives lines first_l..nlines-1; line short_l is one pixel short. Records what the DUT emitted.
    task automatic send_frame(input int first_l, input int nlines, input int short_l, input int mode);
        int len;
        bit vis;
        logic [9:0] ex, ey;
        logic [11:0] pv;
        nvalid = 0; rgb_bad = 0; n_done = 0; n_eline = 0; n_eframe = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1; lock_first = 1'b0;
        for (int l = first_l; l < nlines; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int p = 0; p < len; p++) begin
                @(negedge clk);
                vis = (p >= HVS) && (p < HVS + HV) && (l + 1 >= VVS) && (l + 1 < VVS + VV);
                ex = 10'(p - HVS);
                ey = 10'(l + 1 - VVS);
                pv = vis ? ((mode != 0) ? {ex[3:0], ey[3:0], 4'h5} : 12'hFFF) : 12'h3C7;
                hsync = (p < 2) ? 1'b0 : 1'b1;
                vsync = (l < 2) ? 1'b0 : 1'b1;
                rgb = pv;
                pixpulse = 1'b1;
                @(negedge clk);
                pixpulse = 1'b0;
                if (pix_valid) begin
                    nvalid++;
                    if (!vis || pix_x !== ex || pix_y !== ey || pix_rgb !== pv) rgb_bad++;
                    if (first_x < 0) begin first_x = int'(pix_x); first_y = int'(pix_y); end
                    last_x = int'(pix_x); last_y = int'(pix_y);
                end
                if (frame_done) begin n_done++; last_crc = frame_crc; end
                if (err_line)  n_eline++;
                if (err_frame) n_eframe++;
                if (l == first_l && p == 0) lock_first = locked;
                repeat (2) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid got=%0b exp=0", pix_valid); else n_pass++;
        n_total++; if ({pix_x, pix_y, pix_rgb} !== 32'd0) $display("FAIL rst_pix_data got=%h exp=0", {pix_x, pix_y, pix_rgb}); else n_pass++;
        n_total++; if (frame_crc !== 16'd0) $display("FAIL rst_frame_crc got=%h exp=0000", frame_crc); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL rst_locked got=%0b exp=0", locked); else n_pass++;
        n_total++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
        n_total++; if ({frame_done, err_line, err_frame} !== 3'b000) $display("FAIL rst_pulses got=%b exp=000", {frame_done, err_line, err_frame}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_lock();
        send_frame(0, VT, -1, 0);
        n_total++; if (nvalid !== HV * VV) $display("FAIL lockA_nvalid got=%0d exp=%0d", nvalid, HV * VV); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL lockA_locked got=%0b exp=0", locked); else n_pass++;
        n_total++; if (n_done !== 0) $display("FAIL lockA_done got=%0d exp=0", n_done); else n_pass++;
        send_frame(0, VT, -1, 0);
        n_total++; if (lock_first !== 1'b1) $display("FAIL lockB_locked got=%0b exp=1", lock_first); else n_pass++;
        n_total++; if (n_done !== 1) $display("FAIL lockB_done got=%0d exp=1", n_done); else n_pass++;
        n_total++; if (last_crc !== crc_model(0)) $display("FAIL lockB_crc got=%h exp=%h", last_crc, crc_model(0)); else n_pass++;
        n_total++; if (first_x !== 0 || first_y !== 0) $display("FAIL lockB_first got=%0d,%0d exp=0,0", first_x, first_y); else n_pass++;
        n_total++; if (last_x !== HV - 1 || last_y !== VV - 1) $display("FAIL lockB_last got=%0d,%0d exp=%0d,%0d", last_x, last_y, HV - 1, VV - 1); else n_pass++;
        n_total++; if (rgb_bad !== 0) $display("FAIL lockB_pixels got=%0d bad exp=0", rgb_bad); else n_pass++;
    endtask

    task automatic test_gradient();
        send_frame(0, VT, -1, 1);
        n_total++; if (rgb_bad !== 0) $display("FAIL gradC_pixels got=%0d bad exp=0", rgb_bad); else n_pass++;
        n_total++; if (last_crc !== crc_model(0) || n_done !== 1) $display("FAIL gradC_crc got=%h/%0d exp=%h/1", last_crc, n_done, crc_model(0)); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (last_crc !== crc_model(1) || n_done !== 1) $display("FAIL gradD_crc got=%h/%0d exp=%h/1", last_crc, n_done, crc_model(1)); else n_pass++;
        n_total++; if (nvalid !== HV * VV || rgb_bad !== 0) $display("FAIL gradD_pixels got=%0d/%0d exp=%0d/0", nvalid, rgb_bad, HV * VV); else n_pass++;
        n_total++; if (err_cnt !== 8'd0) $display("FAIL gradD_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
    endtask

    task automatic test_line_err();
        send_frame(0, VT, 5, 1);
        n_total++; if (n_eline !== 1) $display("FAIL lineE_err_line got=%0d exp=1", n_eline); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL lineE_locked got=%0b exp=0", locked); else n_pass++;
        n_total++; if (err_cnt !== 8'd1) $display("FAIL lineE_err_cnt got=%0d exp=1", err_cnt); else n_pass++;
        n_total++; if (nvalid !== HV * VV) $display("FAIL lineE_nvalid got=%0d exp=%0d", nvalid, HV * VV); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (n_done !== 0 || n_eline !== 0) $display("FAIL lineF_done got=%0d/%0d exp=0/0", n_done, n_eline); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL lineF_locked got=%0b exp=0", locked); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (lock_first !== 1'b1 || n_done !== 1) $display("FAIL lineG_relock got=%0b/%0d exp=1/1", lock_first, n_done); else n_pass++;
        n_total++; if (last_crc !== crc_model(1)) $display("FAIL lineG_crc got=%h exp=%h", last_crc, crc_model(1)); else n_pass++;
        n_total++; if (err_cnt !== 8'd1) $display("FAIL lineG_err_cnt got=%0d exp=1", err_cnt); else n_pass++;
    endtask

    task automatic test_frame_err();
        send_frame(0, VT - 1, -1, 1);
        n_total++; if (n_done !== 1 || n_eframe !== 0) $display("FAIL frmH_events got=%0d/%0d exp=1/0", n_done, n_eframe); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (n_eframe !== 1) $display("FAIL frmI_err_frame got=%0d exp=1", n_eframe); else n_pass++;
        n_total++; if (n_done !== 0) $display("FAIL frmI_done got=%0d exp=0", n_done); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL frmI_locked got=%0b exp=0", locked); else n_pass++;
        n_total++; if (err_cnt !== 8'd2) $display("FAIL frmI_err_cnt got=%0d exp=2", err_cnt); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (lock_first !== 1'b1 || n_done !== 1) $display("FAIL frmJ_relock got=%0b/%0d exp=1/1", lock_first, n_done); else n_pass++;
        n_total++; if (last_crc !== crc_model(1)) $display("FAIL frmJ_crc got=%h exp=%h", last_crc, crc_model(1)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send_frame(0, 5, -1, 1);
        rst = 1'b1;
        #1;
        n_total++; if (locked !== 1'b0) $display("FAIL mid_locked got=%0b exp=0", locked); else n_pass++;
        n_total++; if (err_cnt !== 8'd0) $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
        n_total++; if (frame_crc !== 16'd0) $display("FAIL mid_frame_crc got=%h exp=0000", frame_crc); else n_pass++;
        n_total++; if ({pix_valid, pix_x, pix_y, pix_rgb} !== 33'd0) $display("FAIL mid_pix got=%h exp=0", {pix_valid, pix_x, pix_y, pix_rgb}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        send_frame(5, VT, -1, 1);
        n_total++; if (nvalid !== 0 || locked !== 1'b0) $display("FAIL midK_search got=%0d/%0b exp=0/0", nvalid, locked); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (lock_first !== 1'b0 || n_done !== 0) $display("FAIL midL_measure got=%0b/%0d exp=0/0", lock_first, n_done); else n_pass++;
        n_total++; if (nvalid !== HV * VV) $display("FAIL midL_nvalid got=%0d exp=%0d", nvalid, HV * VV); else n_pass++;
        send_frame(0, VT, -1, 1);
        n_total++; if (lock_first !== 1'b1 || n_done !== 1) $display("FAIL midM_relock got=%0b/%0d exp=1/1", lock_first, n_done); else n_pass++;
        n_total++; if (last_crc !== crc_model(1)) $display("FAIL midM_crc got=%h exp=%h", last_crc, crc_model(1)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gradient();
        test_line_err();
        test_frame_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
